// File: rtl/c7bbiu.sv
// Instruction-side BIU: turns one icache line-fill or single-beat request into an AXI4 read burst.
// Optional macro C7BBIU_WRAP_EN: line fills use a WRAP burst from the missing beat (critical word first).
module c7bbiu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        icu_biu_req,
    input  logic [31:3] icu_biu_addr,
    input  logic        icu_biu_single,
    output logic        biu_icu_ack,
    output logic        biu_icu_data_valid,
    output logic        biu_icu_data_last,
    output logic [63:0] biu_icu_data,
    output logic        biu_icu_fault,
    output logic        biu_axi_arvalid,
    input  logic        axi_biu_arready,
    output logic [31:0] biu_axi_araddr,
    output logic [7:0]  biu_axi_arlen,
    output logic [2:0]  biu_axi_arsize,
    output logic [1:0]  biu_axi_arburst,
    output logic [2:0]  biu_axi_arprot,
    input  logic        axi_biu_rvalid,
    output logic        biu_axi_rready,
    input  logic [63:0] axi_biu_rdata,
    input  logic [1:0]  axi_biu_rresp,
    input  logic        axi_biu_rlast
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        RDATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        single_q, single_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        dv_q, dv_d;
    logic        last_q, last_d;
    logic        fault_q, fault_d;
    logic [63:0] data_q, data_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [1:0]  arburst_q, arburst_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [2:0]  arprot_q, arprot_d;

    logic final_beat;
    logic resp_err;

    // Termination comes from the beat counter alone; rlast is only cross-checked.
    assign final_beat = single_q ? (cnt_q == 2'd0) : (cnt_q == 2'd3);
    assign resp_err   = (axi_biu_rresp == 2'b10) || (axi_biu_rresp == 2'b11);

    always_comb begin
        state_d   = state_q;
        single_d  = single_q;
        cnt_d     = cnt_q;
        ack_d     = 1'b0;
        dv_d      = 1'b0;
        last_d    = 1'b0;
        fault_d   = 1'b0;
        data_d    = data_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arburst_d = arburst_q;
        arsize_d  = arsize_q;
        arprot_d  = arprot_q;
        case (state_q)
            IDLE: begin
                if (icu_biu_req) begin
                    state_d  = AR;
                    single_d = icu_biu_single;
                    arsize_d = 3'b011;
                    arprot_d = 3'b100;
                    if (icu_biu_single) begin
                        araddr_d  = {icu_biu_addr, 3'b000};
                        arlen_d   = 8'd0;
                        arburst_d = 2'b01;
                    end else begin
                        arlen_d   = 8'd3;
`ifdef C7BBIU_WRAP_EN
                        araddr_d  = {icu_biu_addr, 3'b000};
                        arburst_d = 2'b10;
`else
                        araddr_d  = {icu_biu_addr[31:5], 5'b00000};
                        arburst_d = 2'b01;
`endif
                    end
                end
            end
            AR: begin
                if (axi_biu_arready) begin
                    state_d = RDATA;
                    ack_d   = 1'b1;
                    cnt_d   = 2'd0;
                end
            end
            RDATA: begin
                if (axi_biu_rvalid) begin
                    data_d  = axi_biu_rdata;
                    dv_d    = 1'b1;
                    last_d  = final_beat;
                    fault_d = resp_err || (axi_biu_rlast != final_beat);
                    cnt_d   = cnt_q + 2'd1;
                    if (final_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            single_q  <= 1'b0;
            cnt_q     <= 2'd0;
            ack_q     <= 1'b0;
            dv_q      <= 1'b0;
            last_q    <= 1'b0;
            fault_q   <= 1'b0;
            data_q    <= 64'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            arburst_q <= 2'd0;
            arsize_q  <= 3'd0;
            arprot_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            single_q  <= single_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            dv_q      <= dv_d;
            last_q    <= last_d;
            fault_q   <= fault_d;
            data_q    <= data_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arburst_q <= arburst_d;
            arsize_q  <= arsize_d;
            arprot_q  <= arprot_d;
        end
    end

    assign biu_axi_arvalid    = (state_q == AR);
    assign biu_axi_rready     = (state_q == RDATA);
    assign biu_axi_araddr     = araddr_q;
    assign biu_axi_arlen      = arlen_q;
    assign biu_axi_arburst    = arburst_q;
    assign biu_axi_arsize     = arsize_q;
    assign biu_axi_arprot     = arprot_q;
    assign biu_icu_ack        = ack_q;
    assign biu_icu_data_valid = dv_q;
    assign biu_icu_data_last  = last_q;
    assign biu_icu_fault      = fault_q;
    assign biu_icu_data       = data_q;

endmodule

// File: tb/tb_c7bbiu.sv
// Bench for c7bbiu: directed vector table, randomized transactions and a mid-burst reset sequence.
// Expectations follow the build: define C7BBIU_WRAP_EN for both RTL and bench to test the WRAP build.
module tb_c7bbiu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        icu_biu_req;
    logic [31:3] icu_biu_addr;
    logic        icu_biu_single;
    logic        biu_icu_ack;
    logic        biu_icu_data_valid;
    logic        biu_icu_data_last;
    logic [63:0] biu_icu_data;
    logic        biu_icu_fault;
    logic        biu_axi_arvalid;
    logic        axi_biu_arready;
    logic [31:0] biu_axi_araddr;
    logic [7:0]  biu_axi_arlen;
    logic [2:0]  biu_axi_arsize;
    logic [1:0]  biu_axi_arburst;
    logic [2:0]  biu_axi_arprot;
    logic        axi_biu_rvalid;
    logic        biu_axi_rready;
    logic [63:0] axi_biu_rdata;
    logic [1:0]  axi_biu_rresp;
    logic        axi_biu_rlast;

    c7bbiu dut (
        .clk                (clk),
        .resetn             (resetn),
        .icu_biu_req        (icu_biu_req),
        .icu_biu_addr       (icu_biu_addr),
        .icu_biu_single     (icu_biu_single),
        .biu_icu_ack        (biu_icu_ack),
        .biu_icu_data_valid (biu_icu_data_valid),
        .biu_icu_data_last  (biu_icu_data_last),
        .biu_icu_data       (biu_icu_data),
        .biu_icu_fault      (biu_icu_fault),
        .biu_axi_arvalid    (biu_axi_arvalid),
        .axi_biu_arready    (axi_biu_arready),
        .biu_axi_araddr     (biu_axi_araddr),
        .biu_axi_arlen      (biu_axi_arlen),
        .biu_axi_arsize     (biu_axi_arsize),
        .biu_axi_arburst    (biu_axi_arburst),
        .biu_axi_arprot     (biu_axi_arprot),
        .axi_biu_rvalid     (axi_biu_rvalid),
        .biu_axi_rready     (biu_axi_rready),
        .axi_biu_rdata      (axi_biu_rdata),
        .axi_biu_rresp      (axi_biu_rresp),
        .axi_biu_rlast      (axi_biu_rlast)
    );

    always #5 clk = ~clk;

`ifdef C7BBIU_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        logic [28:0] addr;
        bit          single;
        int          ar_wait;
        int          rv_mode;   // 0: always valid, 1: 7-cycle pattern, 2: random
        logic [6:0]  rv_pat;
        logic [7:0]  resp;      // 2 bits per beat, beat 0 in [1:0]
        logic [3:0]  rlast;     // one bit per beat
        bit          req_noise;
        logic [31:0] exp_araddr;
        logic [7:0]  exp_arlen;
        logic [1:0]  exp_arburst;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_data = 64'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, biu_icu_ack, 0);
        chk({tag, "_dv"}, biu_icu_data_valid, 0);
        chk({tag, "_last"}, biu_icu_data_last, 0);
        chk({tag, "_fault"}, biu_icu_fault, 0);
        chk({tag, "_data"}, biu_icu_data, 0);
        chk({tag, "_arvalid"}, biu_axi_arvalid, 0);
        chk({tag, "_rready"}, biu_axi_rready, 0);
        chk({tag, "_araddr"}, biu_axi_araddr, 0);
        chk({tag, "_arlen"}, biu_axi_arlen, 0);
        chk({tag, "_arburst"}, biu_axi_arburst, 0);
        chk({tag, "_arsize"}, biu_axi_arsize, 0);
        chk({tag, "_arprot"}, biu_axi_arprot, 0);
    endtask

    task automatic chk_beat(input bit pend, input logic [63:0] d, input bit l, input bit f);
        chk("data_valid", biu_icu_data_valid, pend);
        chk("data", biu_icu_data, pend ? d : exp_data);
        chk("data_last", biu_icu_data_last, pend ? l : 1'b0);
        chk("fault", biu_icu_fault, pend ? f : 1'b0);
    endtask

    // Reference AR address from the request: byte address, line-aligned for INCR line fills.
    function automatic logic [31:0] model_araddr(input logic [28:0] a, input bit single);
        logic [31:0] byte_addr;
        byte_addr = {a, 3'b000};
        if (single || WRAP) return byte_addr;
        return byte_addr & ~32'd31;
    endfunction

    // One full transaction from an IDLE start; ends two cycles after the final beat is delivered.
    task automatic do_txn(input vec_t v);
        int          nb;
        int          n;
        int          cyc;
        bit          pend;
        bit          first;
        bit          rv;
        logic [63:0] pd;
        bit          pl;
        bit          pf;
        logic [1:0]  rs;
        nb = v.single ? 1 : 4;
        n = 0;
        cyc = 0;
        pend = 0;
        first = 1;
        pd = '0;
        pl = 0;
        pf = 0;
        icu_biu_req = 1'b1;
        icu_biu_addr = v.addr;
        icu_biu_single = v.single;
        axi_biu_arready = 1'b0;
        axi_biu_rvalid = 1'b0;
        @(negedge clk);
        chk("idle_arvalid", biu_axi_arvalid, 0);
        chk("idle_rready", biu_axi_rready, 0);
        @(posedge clk); #1;
        icu_biu_req = 1'b0;
        for (int k = 0; k <= v.ar_wait; k++) begin
            axi_biu_arready = (k == v.ar_wait);
            if (v.req_noise) begin
                icu_biu_req = 1'($urandom_range(0, 1));
                icu_biu_addr = 29'($urandom);
                icu_biu_single = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("ar_arvalid", biu_axi_arvalid, 1);
            chk("ar_araddr", biu_axi_araddr, v.exp_araddr);
            chk("ar_arlen", biu_axi_arlen, v.exp_arlen);
            chk("ar_arburst", biu_axi_arburst, v.exp_arburst);
            chk("ar_arsize", biu_axi_arsize, 3'b011);
            chk("ar_arprot", biu_axi_arprot, 3'b100);
            chk("ar_rready", biu_axi_rready, 0);
            chk("ar_ack", biu_icu_ack, 0);
            @(posedge clk); #1;
        end
        axi_biu_arready = 1'b0;
        icu_biu_req = 1'b0;
        while (n < nb && cyc < 200) begin
            case (v.rv_mode)
                0: rv = 1'b1;
                1: rv = v.rv_pat[cyc % 7];
                default: rv = ($urandom_range(0, 3) != 0);
            endcase
            rs = v.resp[2*n +: 2];
            axi_biu_rvalid = rv;
            axi_biu_rdata = {$urandom, $urandom};
            axi_biu_rresp = rs;
            axi_biu_rlast = v.rlast[n];
            if (v.req_noise) icu_biu_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rd_ack", biu_icu_ack, first);
            chk("rd_rready", biu_axi_rready, 1);
            chk("rd_arvalid", biu_axi_arvalid, 0);
            chk_beat(pend, pd, pl, pf);
            first = 0;
            @(posedge clk); #1;
            pend = rv;
            if (rv) begin
                pd = axi_biu_rdata;
                pl = (n == nb - 1);
                pf = rs[1] || (v.rlast[n] != pl);
                exp_data = pd;
                n++;
            end
            cyc++;
        end
        if (n < nb) begin
            bad++;
            total++;
            $display("FAIL rdata_timeout actual=%0d beats required=%0d", n, nb);
        end
        axi_biu_rvalid = 1'b0;
        axi_biu_rlast = 1'b0;
        axi_biu_rresp = 2'b00;
        icu_biu_req = 1'b0;
        @(negedge clk);
        chk("end_rready", biu_axi_rready, 0);
        chk("end_arvalid", biu_axi_arvalid, 0);
        chk("end_ack", biu_icu_ack, 0);
        chk_beat(pend, pd, pl, pf);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle2_rready", biu_axi_rready, 0);
        chk_beat(1'b0, pd, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];

    initial begin
        vec_t rv_vec;
        logic [3:0] good_last;
        vecs[0] = '{29'h0000_0403, 1'b0, 0, 0, 7'h00, 8'h00, 4'b1000, 1'b0,
                    WRAP ? 32'h2018 : 32'h2000, 8'd3, WRAP ? 2'b10 : 2'b01};
        vecs[1] = '{29'h0000_0001, 1'b1, 0, 0, 7'h00, 8'h00, 4'b0001, 1'b0,
                    32'h0000_0008, 8'd0, 2'b01};
        vecs[2] = '{29'h0000_0403, 1'b0, 5, 1, 7'h59, 8'h00, 4'b1000, 1'b1,
                    WRAP ? 32'h2018 : 32'h2000, 8'd3, WRAP ? 2'b10 : 2'b01};
        vecs[3] = '{29'h0000_0403, 1'b0, 0, 0, 7'h00, 8'h20, 4'b1000, 1'b0,
                    WRAP ? 32'h2018 : 32'h2000, 8'd3, WRAP ? 2'b10 : 2'b01};
        vecs[4] = '{29'h0000_0403, 1'b0, 0, 0, 7'h00, 8'h00, 4'b0010, 1'b0,
                    WRAP ? 32'h2018 : 32'h2000, 8'd3, WRAP ? 2'b10 : 2'b01};
        vecs[5] = '{29'h0000_0002, 1'b1, 1, 0, 7'h00, 8'h03, 4'b0000, 1'b0,
                    32'h0000_0010, 8'd0, 2'b01};
        vecs[6] = '{29'h0012_3456, 1'b0, 2, 0, 7'h00, 8'h55, 4'b1000, 1'b0,
                    WRAP ? 32'h0091_A2B0 : 32'h0091_A2A0, 8'd3, WRAP ? 2'b10 : 2'b01};
        vecs[7] = '{29'h1FFF_FFFF, 1'b0, 0, 2, 7'h00, 8'h00, 4'b1000, 1'b0,
                    WRAP ? 32'hFFFF_FFF8 : 32'hFFFF_FFE0, 8'd3, WRAP ? 2'b10 : 2'b01};

        resetn = 1'b0;
        icu_biu_req = 1'b0;
        icu_biu_addr = '0;
        icu_biu_single = 1'b0;
        axi_biu_arready = 1'b0;
        axi_biu_rvalid = 1'b0;
        axi_biu_rdata = '0;
        axi_biu_rresp = 2'b00;
        axi_biu_rlast = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_data = 64'd0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Reset after the second beat of a line fill, then a clean request.
        icu_biu_req = 1'b1;
        icu_biu_addr = 29'h0000_0403;
        icu_biu_single = 1'b0;
        axi_biu_arready = 1'b1;
        axi_biu_rvalid = 1'b1;
        axi_biu_rdata = 64'hDEAD_BEEF_0123_4567;
        axi_biu_rresp = 2'b00;
        axi_biu_rlast = 1'b0;
        @(posedge clk); #1;
        icu_biu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_dv", biu_icu_data_valid, 1);
        resetn = 1'b0;
        #1;
        chk_all_zero("midrst");
        axi_biu_arready = 1'b0;
        axi_biu_rvalid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_data = 64'd0;
        do_txn(vecs[1]);

        for (int i = 0; i < 24; i++) begin
            rv_vec.addr = 29'($urandom);
            rv_vec.single = 1'($urandom_range(0, 1));
            rv_vec.ar_wait = $urandom_range(0, 3);
            rv_vec.rv_mode = 2;
            rv_vec.rv_pat = 7'h00;
            rv_vec.resp = 8'($urandom);
            good_last = rv_vec.single ? 4'b0001 : 4'b1000;
            rv_vec.rlast = ($urandom_range(0, 3) == 0) ? 4'($urandom) : good_last;
            rv_vec.req_noise = 1'($urandom_range(0, 1));
            rv_vec.exp_araddr = model_araddr(rv_vec.addr, rv_vec.single);
            rv_vec.exp_arlen = rv_vec.single ? 8'd0 : 8'd3;
            rv_vec.exp_arburst = (!rv_vec.single && WRAP) ? 2'b10 : 2'b01;
            do_txn(rv_vec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
